pc_sequencer: RTL

Next-address controller for the 32-bit program counter register. Each cycle it computes the `Address` fed to the PC register from the current `PCResult`: sequential increment, a branch or jump redirect, hold on stall, or hold on halt. It buffers a redirect that arrives during a stall and pulses `Flush` to the fetch/decode stages when a redirect takes effect. It sits between the hazard/branch logic and the PC register, and requires no change to the PC register itself.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/redirect_buffer.sv | 44 ++++
 rtl/pc_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-side control blocks: word width, alignment
// mask, sequencer state encoding and the redirect-selection helper.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        STALL  = 2'd2,
        HALTED = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] target;
    } redirect_t;

    // The branch is older than the jump in the pipe, so it wins; targets are word aligned.
    function automatic redirect_t select_redirect(
        input logic              branch_taken,
        input logic [WORD_W-1:0] branch_target,
        input logic              jump,
        input logic [WORD_W-1:0] jump_target
    );
        redirect_t r;
        r.valid  = branch_taken | jump;
        r.target = (branch_taken ? branch_target : jump_target) & PC_ALIGN_MASK;
        return r;
    endfunction

endpackage

// File: rtl/redirect_buffer.sv
// Single-entry holding slot for a redirect that arrives while the PC is stalled.
// The first redirect loaded is kept until cleared; later loads are dropped.
module redirect_buffer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_target,
    input  logic              clear,
    output logic              pend_valid,
    output logic [WORD_W-1:0] pend_target
);

    logic              pend_valid_q, pend_valid_d;
    logic [WORD_W-1:0] pend_target_q, pend_target_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (clear) begin
            pend_valid_d = 1'b0;
        end else if (load && !pend_valid_q) begin
            pend_valid_d  = 1'b1;
            pend_target_d = load_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pend_valid  = pend_valid_q;
    assign pend_target = pend_target_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the program counter: increment, redirect, stall
// hold and sticky halt, with a one-deep buffer for redirects seen during a stall.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WORD_W-1:0] INCREMENT    = 32'd4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WORD_W-1:0] PCResult,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [WORD_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [WORD_W-1:0] JumpTarget,
    input  logic              Halt,
    output logic [WORD_W-1:0] Address,
    output logic              Flush,
    output logic              Halted
);

    seq_state_e        state_q, state_d;
    redirect_t         redir;
    logic              buf_load;
    logic              buf_clear;
    logic              pend_valid;
    logic [WORD_W-1:0] pend_target;

    assign redir = select_redirect(BranchTaken, BranchTarget, Jump, JumpTarget);

    redirect_buffer u_redirect_buffer (
        .clk         (Clk),
        .rst_n       (Reset),
        .load        (buf_load),
        .load_target (redir.target),
        .clear       (buf_clear),
        .pend_valid  (pend_valid),
        .pend_target (pend_target)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = Halt ? HALTED : RUN;
            RUN: begin
                if (Halt)       state_d = HALTED;
                else if (Stall) state_d = STALL;
            end
            STALL: begin
                if (Halt)        state_d = HALTED;
                else if (!Stall) state_d = RUN;
            end
            HALTED:  state_d = HALTED;
        endcase
    end

    // Halt outranks everything outside BOOT: PC is held, no flush, and any buffered redirect is dropped.
    always_comb begin
        Address   = PCResult;
        Flush     = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        unique case (state_q)
            BOOT: begin
                Address = RESET_VECTOR;
                Flush   = 1'b1;
            end
            RUN: begin
                if (Halt) begin
                    Address = PCResult;
                end else if (Stall) begin
                    buf_load = redir.valid;
                end else if (redir.valid) begin
                    Address = redir.target;
                    Flush   = 1'b1;
                end else begin
                    Address = PCResult + INCREMENT;
                end
            end
            STALL: begin
                if (Halt) begin
                    buf_clear = 1'b1;
                end else if (Stall) begin
                    buf_load = redir.valid;
                end else if (pend_valid) begin
                    Address   = pend_target;
                    Flush     = 1'b1;
                    buf_clear = 1'b1;
                end else if (redir.valid) begin
                    Address = redir.target;
                    Flush   = 1'b1;
                end else begin
                    Address = PCResult + INCREMENT;
                end
            end
            HALTED: begin
                Address = PCResult;
            end
        endcase
    end

    assign Halted = (state_q == HALTED);

endmodule
